// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared definitions for the instruction-memory fetch port.
//   NOP_INSTR : word returned alongside an error response (addi x0,x0,0)
//   ADDR_W    : width of fetch byte addresses
//   idx_w()   : word-index width for a given array depth
//   rsp_t     : response record {data, err, addr} at the default 32-bit XLEN
//   rsp_w()   : packed response width for an arbitrary XLEN
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          ADDR_W    = 32;

    typedef struct packed {
        logic [31:0]       data;
        logic              err;
        logic [ADDR_W-1:0] addr;
    } rsp_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Same {data, err, addr} layout as rsp_t, with the data field widened to xlen.
    function automatic int rsp_w(input int xlen);
        return xlen + 1 + ADDR_W;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo
//   Small synchronous response FIFO. The head entry is visible on head_data
//   as soon as it is written, so no separate read cycle is needed.
//   The head reads as zero while the FIFO is empty.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   empties the FIFO at the next edge
//   push       in   write push_data (ignored when full and not popping)
//   push_data  in   entry to write
//   pop        in   consume the head entry (ignored when empty)
//   head_data  out  oldest entry, zero when empty
//   head_valid out  FIFO is not empty
//   count      out  number of stored entries
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int WIDTH = $bits(rsp_t),
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port
//   Instruction memory behind a valid/ready fetch port. Contents are written
//   through the load port before the core runs. Misaligned or out-of-range
//   fetches never touch the array and return NOP_INSTR with rsp_err set.
//   Read path: registered array read, optional second register stage
//   (READ_LAT=2), then a READ_LAT+1 entry response FIFO. Requests are only
//   accepted when a FIFO slot is guaranteed, so back-pressure never drops data.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   discard every in-flight and buffered response
//   req_valid  in   fetch request valid
//   req_ready  out  request accepted when req_valid && req_ready
//   req_addr   in   instruction byte address
//   rsp_valid  out  response valid
//   rsp_ready  in   consumer takes the response
//   rsp_data   out  instruction word (NOP_INSTR on error)
//   rsp_err    out  misaligned or out-of-range fetch
//   rsp_addr   out  echo of the request address
//   ld_en      in   program-load write strobe (blocks fetch acceptance)
//   ld_addr    in   word index to write
//   ld_data    in   word to write
module imem_fetch_port #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 256,
    parameter int              READ_LAT  = 1,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(imem_pkg::NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [XLEN-1:0]          rsp_data,
    output logic                     rsp_err,
    output logic [31:0]              rsp_addr,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [XLEN-1:0]          ld_data
);

    import imem_pkg::*;

    localparam int IDX_W = idx_w(DEPTH);
    localparam int FD    = READ_LAT + 1;
    localparam int RW    = rsp_w(XLEN);
    localparam int CW    = $clog2(FD + 1);

    logic [XLEN-1:0]  mem [DEPTH];

    logic             run;
    logic             req_fire;
    logic             addr_err;
    logic [IDX_W-1:0] idx;

    logic             s1_vld;
    logic             s1_err;
    logic [XLEN-1:0]  s1_data;
    logic [31:0]      s1_addr;
    logic [RW-1:0]    s1_rsp;

    logic             out_vld;
    logic [RW-1:0]    out_rsp;
    logic [1:0]       in_flight;

    logic [RW-1:0]    head;
    logic             head_valid;
    logic [CW-1:0]    count;
    logic             pop;
    logic [3:0]       occ;
    logic [3:0]       cap;

    // Address decode: any set bit above the array range means out of range.
    assign idx      = req_addr[IDX_W+1:2];
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:IDX_W+2] != '0);

    // A pop in this cycle frees a slot, which keeps one fetch per cycle
    // flowing while the consumer is ready.
    assign pop       = rsp_ready && head_valid;
    assign occ       = 4'(count) + 4'(in_flight);
    assign cap       = 4'(FD) + 4'(pop);
    assign req_ready = run && !ld_en && !flush && (occ < cap);
    assign req_fire  = req_valid && req_ready;

    // req_ready stays low until the first edge after reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Fetches cannot be accepted while ld_en is high, so load and read never
    // collide on the array.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) s1_vld <= 1'b0;
        else                 s1_vld <= req_fire;
        if (req_fire) begin
            s1_err  <= addr_err;
            s1_addr <= req_addr;
        end
        if (req_fire && !addr_err) s1_data <= mem[idx];
    end

    assign s1_rsp = {(s1_err ? NOP_INSTR : s1_data), s1_err, s1_addr};

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic          s2_vld;
            logic [RW-1:0] s2_rsp;

            always_ff @(posedge clk) begin
                if (!rst_n || flush) s2_vld <= 1'b0;
                else                 s2_vld <= s1_vld;
                if (s1_vld) s2_rsp <= s1_rsp;
            end

            assign out_vld   = s2_vld;
            assign out_rsp   = s2_rsp;
            assign in_flight = {1'b0, s1_vld} + {1'b0, s2_vld};
        end else begin : g_lat1
            assign out_vld   = s1_vld;
            assign out_rsp   = s1_rsp;
            assign in_flight = {1'b0, s1_vld};
        end
    endgenerate

    imem_rsp_fifo #(
        .WIDTH (RW),
        .DEPTH (FD)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (out_vld),
        .push_data  (out_rsp),
        .pop        (pop),
        .head_data  (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign rsp_valid = head_valid;
    assign rsp_data  = head[RW-1 -: XLEN];
    assign rsp_err   = head[32];
    assign rsp_addr  = head[31:0];

endmodule
